// File: rtl/fe_sender_pkg.sv
// fe_sender_pkg
// Shared definitions for the Fe symbol sender.
//   state_t      - sender FSM states; PAR only reached when FE_SENDER_PARITY_EN is defined,
//                  but the encoding is identical in both builds
//   *_LEVEL      - serial line levels for idle, start and stop bits
//   even_parity  - parity bit appended to a 2-bit symbol
//   frame_state  - true for the states that put a frame bit on the line
package fe_sender_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        D0    = 3'd2,
        D1    = 3'd3,
        PAR   = 3'd4,
        STOP  = 3'd5,
        ACK   = 3'd6
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Even parity: the parity bit makes the number of ones in {sym, parity} even.
    function automatic logic even_parity(input logic [1:0] sym);
        return sym[0] ^ sym[1];
    endfunction

    // States during which a frame is on the wire.
    function automatic logic frame_state(input state_t st);
        return (st == START) || (st == D0) || (st == D1) || (st == PAR) || (st == STOP);
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2
// Two-flop synchroniser for asynchronous inputs, WIDTH bits wide.
// Each bit is synchronised independently; the caller guarantees that
// multi-bit data is stable while its qualifying request is high.
// Ports:
//   clk    - destination clock
//   reset  - asynchronous active-low reset, clears both flop stages
//   d      - asynchronous inputs
//   q      - synchronised outputs, two clock edges after d
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fe_symbol_sender.sv
// fe_symbol_sender
// Captures a 2-bit symbol from the Fe handshake controller, sends it as a
// framed symbol on a single-wire serial line (start, bit0, bit1, [parity],
// stop, each BAUD_DIV clocks long) and acknowledges with a 4-phase handshake.
// A running count of completed frames is kept and can be cleared.
//
// Build option: define FE_SENDER_PARITY_EN to insert an even-parity bit
// between bit1 and the stop bit (5-bit frame instead of 4-bit).
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   dt         - async request from Fe, symbol valid while high
//   bit0,bit1  - async symbol bits, stable while dt is high
//   cclear     - async counter clear request
//   senack     - handshake acknowledge back to Fe
//   tx         - serial line, idles high
//   busy       - high while a frame is on the line
//   sym_count  - number of completed frames, wraps
module fe_symbol_sender
    import fe_sender_pkg::*;
#(
    parameter int BAUD_DIV = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dt,
    input  logic             bit0,
    input  logic             bit1,
    input  logic             cclear,
    output logic             senack,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] sym_count
);

    // Baud counter counts down from BAUD_DIV-1 to 0 within each bit slot.
    localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

    logic [3:0]    sync_q;
    logic          dt_s;
    logic          b0_s;
    logic          b1_s;
    logic          cc_s;

    state_t        state;
    logic [1:0]    sym;
    logic [BW-1:0] baud_cnt;
    logic          bit_done;
    logic          frame_done;

    sync2 #(
        .WIDTH (4)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({cclear, bit1, bit0, dt}),
        .q     (sync_q)
    );

    assign dt_s = sync_q[0];
    assign b0_s = sync_q[1];
    assign b1_s = sync_q[2];
    assign cc_s = sync_q[3];

    assign bit_done   = (baud_cnt == '0);
    assign frame_done = (state == STOP) && bit_done;

    // Sender FSM. Every output is registered and takes its new value on the
    // edge that enters a state, so tx changes exactly at bit boundaries.
    // Each timed state reloads the baud counter on entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            sym      <= '0;
            baud_cnt <= '0;
            tx       <= IDLE_LEVEL;
            senack   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dt_s) begin
                        sym      <= {b1_s, b0_s};
                        state    <= START;
                        tx       <= START_LEVEL;
                        busy     <= 1'b1;
                        baud_cnt <= BAUD_LAST;
                    end
                end

                START: begin
                    if (bit_done) begin
                        state    <= D0;
                        tx       <= sym[0];
                        baud_cnt <= BAUD_LAST;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

                D0: begin
                    if (bit_done) begin
                        state    <= D1;
                        tx       <= sym[1];
                        baud_cnt <= BAUD_LAST;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

                D1: begin
                    if (bit_done) begin
`ifdef FE_SENDER_PARITY_EN
                        state    <= PAR;
                        tx       <= even_parity(sym);
`else
                        state    <= STOP;
                        tx       <= STOP_LEVEL;
`endif
                        baud_cnt <= BAUD_LAST;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

`ifdef FE_SENDER_PARITY_EN
                PAR: begin
                    if (bit_done) begin
                        state    <= STOP;
                        tx       <= STOP_LEVEL;
                        baud_cnt <= BAUD_LAST;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_done) begin
                        state    <= ACK;
                        tx       <= IDLE_LEVEL;
                        busy     <= 1'b0;
                        senack   <= 1'b1;
                        baud_cnt <= '0;
                    end else begin
                        baud_cnt <= baud_cnt - 1'b1;
                    end
                end

                // Hold the acknowledge until Fe withdraws its request; a
                // request dropped mid-frame yields a single-cycle acknowledge.
                ACK: begin
                    if (!dt_s) begin
                        state  <= IDLE;
                        senack <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    tx       <= IDLE_LEVEL;
                    busy     <= 1'b0;
                    senack   <= 1'b0;
                    baud_cnt <= '0;
                end
            endcase
        end
    end

    // Completed-frame counter; a clear request overrides a simultaneous increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_count <= '0;
        end else if (cc_s) begin
            sym_count <= '0;
        end else if (frame_done) begin
            sym_count <= sym_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fe_symbol_sender.sv
// tb_fe_symbol_sender
// Self-checking bench for fe_symbol_sender. Cycle numbering inside a frame
// follows the handshake: cycle 0 is the first cycle with the synchronised
// request high, the frame occupies cycles 1..FC and the acknowledge rises in
// cycle FC+1. Expected waveforms come from the frame rules, not from the RTL.
module tb_fe_symbol_sender;

    localparam int B  = 4;
    localparam int CW = 8;
`ifdef FE_SENDER_PARITY_EN
    localparam int NBITS = 5;
`else
    localparam int NBITS = 4;
`endif
    localparam int FC   = NBITS * B;
    localparam int NCAP = FC + 4;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic          dt     = 1'b0;
    logic          bit0   = 1'b0;
    logic          bit1   = 1'b0;
    logic          cclear = 1'b0;
    logic          senack;
    logic          tx;
    logic          busy;
    logic [CW-1:0] sym_count;

    int            n_checks  = 0;
    int            n_fail    = 0;
    int            exp_count = 0;
    logic [63:0]   obs_tx;
    logic [63:0]   obs_busy;
    logic [63:0]   obs_ack;

    fe_symbol_sender #(
        .BAUD_DIV (B),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dt        (dt),
        .bit0      (bit0),
        .bit1      (bit1),
        .cclear    (cclear),
        .senack    (senack),
        .tx        (tx),
        .busy      (busy),
        .sym_count (sym_count)
    );

    always #5 clk = ~clk;

    // Reference line waveform for cycles 1..NCAP: each frame bit lasts B cycles,
    // the line is high once the frame is over.
    function automatic logic [63:0] model_tx(input logic [1:0] s);
        logic frame_bits[$];
        int   slot;
        model_tx = '0;
        frame_bits.push_back(1'b0);
        frame_bits.push_back(s[0]);
        frame_bits.push_back(s[1]);
`ifdef FE_SENDER_PARITY_EN
        frame_bits.push_back(s[0] ^ s[1]);
`endif
        frame_bits.push_back(1'b1);
        for (int c = 1; c <= NCAP; c++) begin
            slot = (c - 1) / B;
            model_tx[c-1] = (slot < frame_bits.size()) ? frame_bits[slot] : 1'b1;
        end
    endfunction

    function automatic logic [63:0] model_busy();
        model_busy = '0;
        for (int c = 1; c <= NCAP; c++) model_busy[c-1] = (c <= FC);
    endfunction

    // With the request held the acknowledge stays high after the frame;
    // with the request dropped early it is a single-cycle pulse.
    function automatic logic [63:0] model_ack(input bit held);
        model_ack = '0;
        for (int c = 1; c <= NCAP; c++) model_ack[c-1] = held ? (c > FC) : (c == FC + 1);
    endfunction

    task automatic start_symbol(input logic [1:0] s);
        bit0 = s[0];
        bit1 = s[1];
        dt   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic capture(input int drop_at);
        obs_tx   = '0;
        obs_busy = '0;
        obs_ack  = '0;
        for (int c = 1; c <= NCAP; c++) begin
            @(posedge clk);
            #1;
            obs_tx[c-1]   = tx;
            obs_busy[c-1] = busy;
            obs_ack[c-1]  = senack;
            if (c == drop_at) dt = 1'b0;
        end
    endtask

    task automatic release_dt(output int lat);
        dt  = 1'b0;
        lat = -1;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (!senack) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic wait_senack(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < FC + 16; n++) begin
            if (senack) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        dt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks += 4;
        if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_tx got=%b want=1", tx); end
        if (senack !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_senack got=%b want=0", senack); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        if (sym_count !== '0) begin n_fail++; $display("[TB] FAIL reset_count got=%0d want=0", sym_count); end
        dt = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Full check of one held-request handshake on symbol s.
    task automatic test_frame(input logic [1:0] s, input string tag);
        int lat;
        start_symbol(s);
        capture(0);
        exp_count = (exp_count + 1) % 256;
        n_checks += 5;
        if (obs_tx !== model_tx(s)) begin
            n_fail++; $display("[TB] FAIL %s_tx sym=%b got=%h want=%h", tag, s, obs_tx, model_tx(s));
        end
        if (obs_busy !== model_busy()) begin
            n_fail++; $display("[TB] FAIL %s_busy sym=%b got=%h want=%h", tag, s, obs_busy, model_busy());
        end
        if (obs_ack !== model_ack(1'b1)) begin
            n_fail++; $display("[TB] FAIL %s_ack sym=%b got=%h want=%h", tag, s, obs_ack, model_ack(1'b1));
        end
        if (sym_count !== CW'(exp_count)) begin
            n_fail++; $display("[TB] FAIL %s_count got=%0d want=%0d", tag, sym_count, exp_count);
        end
        release_dt(lat);
        if (lat != 3) begin
            n_fail++; $display("[TB] FAIL %s_ack_drop got=%0d want=3", tag, lat);
        end
    endtask

    task automatic test_random_symbols();
        for (int i = 0; i < 10; i++) test_frame(2'($urandom_range(3)), "rand");
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit overlap;
        int lat;
        cclear = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cclear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_count = 0;
        n_checks++;
        if (sym_count !== '0) begin n_fail++; $display("[TB] FAIL b2b_clear got=%0d want=0", sym_count); end
        overlap = 1'b0;
        for (int i = 0; i < 256; i++) begin
            start_symbol(2'($urandom_range(3)));
            ok = 1'b0;
            for (int n = 0; n < FC + 16; n++) begin
                if (busy && senack) overlap = 1'b1;
                if (senack) begin
                    ok = 1'b1;
                    break;
                end
                @(posedge clk);
                #1;
            end
            exp_count = (exp_count + 1) % 256;
            n_checks += 2;
            if (!ok) begin n_fail++; $display("[TB] FAIL b2b_timeout frame=%0d got=no_ack want=ack", i); end
            if (sym_count !== CW'(exp_count)) begin
                n_fail++; $display("[TB] FAIL b2b_count frame=%0d got=%0d want=%0d", i, sym_count, exp_count);
            end
            if (busy && senack) overlap = 1'b1;
            release_dt(lat);
        end
        n_checks++;
        if (overlap) begin n_fail++; $display("[TB] FAIL b2b_busy_ack_overlap got=1 want=0"); end
    endtask

    // Clear request synchronised so it lands on the frame-completion edge.
    task automatic test_clear_race();
        bit ok;
        int lat;
        start_symbol(2'b01);
        wait_senack(ok);
        release_dt(lat);
        exp_count = (exp_count + 1) % 256;
        n_checks += 3;
        if (sym_count !== CW'(exp_count)) begin
            n_fail++; $display("[TB] FAIL clr_precount got=%0d want=%0d", sym_count, exp_count);
        end
        start_symbol(2'b10);
        repeat (FC - 2) @(posedge clk);
        #1;
        cclear = 1'b1;
        @(posedge clk);
        #1;
        cclear = 1'b0;
        wait_senack(ok);
        exp_count = 0;
        if (!ok) begin n_fail++; $display("[TB] FAIL clr_timeout got=no_ack want=ack"); end
        if (sym_count !== '0) begin n_fail++; $display("[TB] FAIL clr_wins got=%0d want=0", sym_count); end
        release_dt(lat);
    endtask

    task automatic test_drop_mid_frame();
        logic [1:0] s;
        s = 2'($urandom_range(3));
        start_symbol(s);
        capture(B + 1);
        exp_count = (exp_count + 1) % 256;
        n_checks += 5;
        if (obs_tx !== model_tx(s)) begin
            n_fail++; $display("[TB] FAIL drop_tx sym=%b got=%h want=%h", s, obs_tx, model_tx(s));
        end
        if (obs_busy !== model_busy()) begin
            n_fail++; $display("[TB] FAIL drop_busy got=%h want=%h", obs_busy, model_busy());
        end
        if (obs_ack !== model_ack(1'b0)) begin
            n_fail++; $display("[TB] FAIL drop_ack_pulse got=%h want=%h", obs_ack, model_ack(1'b0));
        end
        if (sym_count !== CW'(exp_count)) begin
            n_fail++; $display("[TB] FAIL drop_count got=%0d want=%0d", sym_count, exp_count);
        end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL drop_idle_busy got=%b want=0", busy); end
        test_frame(2'($urandom_range(3)), "after_drop");
    endtask

    task automatic test_reset_mid_frame();
        start_symbol(2'b00);
        repeat (2 * B + 2) @(posedge clk);
        #2;
        n_checks += 5;
        if (tx !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_pre_tx got=%b want=0", tx); end
        reset = 1'b0;
        #1;
        if (tx !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_mid_tx got=%b want=1", tx); end
        if (senack !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_senack got=%b want=0", senack); end
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mid_busy got=%b want=0", busy); end
        if (sym_count !== '0) begin n_fail++; $display("[TB] FAIL rst_mid_count got=%0d want=0", sym_count); end
        dt = 1'b0;
        exp_count = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_frame(2'b01, "post_rst");
    endtask

    initial begin
        $display("[TB] fe_symbol_sender bench, BAUD_DIV=%0d frame_bits=%0d", B, NBITS);
        test_reset();
        test_frame(2'b10, "sym10");
        test_frame(2'b11, "sym11");
        test_random_symbols();
        test_back_to_back();
        test_clear_race();
        test_drop_mid_frame();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fe_symbol_sender.md
Name: fe_symbol_sender

Overview:
- Downstream consumer of the Fe handshake controller.
- Captures the 2-bit symbol {bit1, bit0} when Fe raises Dt, serialises it onto a single-wire line as a framed symbol, and returns senack with a 4-phase handshake.
- Keeps a running count of completed symbols, cleared by Cclear.
- Synchronous design; all Fe-side inputs are asynchronous and are synchronised on entry.

Parameters:
- BAUD_DIV, 4, clock cycles per serial bit; legal range ≥1.
- CNT_W, 8, width of the completed-symbol counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; low forces the reset state immediately.
- dt  input  1  async request from Fe; high means a symbol is valid.
- bit0  input  1  async symbol LSB; stable while dt is high.
- bit1  input  1  async symbol MSB; stable while dt is high.
- cclear  input  1  async request to clear the counter.
- senack  output  1  handshake acknowledge to Fe.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in flight (START through STOP).
- sym_count  output  CNT_W  completed-frame count.

Behaviour:
- Reset values (reset low, asynchronous):
  - state=IDLE, tx=1, senack=0, busy=0, sym_count=0, baud counter=0.
  - Synchroniser flops cleared.
- Synchronisation:
  - dt, bit0, bit1 and cclear each pass through a 2-flop synchroniser; dt_s, b0_s, b1_s and cc_s denote the outputs.
  - Latency from pin to dt_s is 2 cycles.
- States: IDLE, START, D0, D1, STOP, ACK.
  - IDLE: tx=1. When dt_s=1, latch sym={b1_s,b0_s} and go to START on the next edge.
  - START: tx=0.
  - D0: tx=sym[0].
  - D1: tx=sym[1].
  - STOP: tx=1.
  - ACK: senack=1, tx=1. Stays in ACK while dt_s=1; goes to IDLE on the first cycle dt_s=0, and senack drops on that same edge.
- Bit timing:
  - Each of START, D0, D1 and STOP lasts exactly BAUD_DIV cycles.
  - The baud counter reloads on every state entry.
  - tx is registered and changes on the edge that enters the state.
- Counter:
  - sym_count increments by 1 on the STOP→ACK edge.
  - Wraps from 2^CNT_W−1 to 0.
- Counter clear:
  - cc_s=1 forces sym_count=0.
  - If cc_s=1 on the same edge as an increment, the clear wins and the result is 0.
- Handshake rules:
  - A new symbol is accepted only from IDLE, so senack must first drop.
  - dt held high after ACK→IDLE cannot happen because ACK exits only on dt_s=0.
  - If dt drops mid-frame, the frame completes, ACK is entered, senack pulses for exactly 1 cycle, then the block returns to IDLE.
- busy = 1 in START, D0, D1 and STOP (and PAR when enabled); 0 otherwise.
- Reset mid-frame: tx returns to 1 immediately, no partial ACK, and the frame is discarded.
- Minimum turnaround, dt pin rise to senack with BAUD_DIV=B: 2 (sync) + 1 + 4B cycles. With PARITY_EN this becomes 2 + 1 + 5B.

Optional Feature:
- Macro: FE_SENDER_PARITY_EN.
- Defined:
  - State PAR is inserted between D1 and STOP.
  - PAR drives tx = sym[0]^sym[1] (even parity) for BAUD_DIV cycles.
  - The frame is 5 bits long.
- Undefined:
  - No PAR state and a 4-bit frame.
  - Port list identical in both builds.

Decomposition:
- Package fe_sender_pkg:
  - state enum type (IDLE, START, D0, D1, PAR, STOP, ACK), encoding shared by both builds.
  - constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- Sub-module sync2:
  - parameterised width, 2-flop synchroniser with asynchronous active-low reset.
  - Instantiated once, 4 bits wide.

Test Plan (BAUD_DIV=4, CNT_W=8; cycle 0 = first edge with dt_s=1):
- Symbol 2'b10, parity disabled:
  - tx = 0 for cycles 1–4, 0 for 5–8, 1 for 9–12, 1 for 13–16.
  - senack=1 from cycle 17; drop dt → senack=0 three cycles after the pin falls.
  - sym_count=1.
- 256 back-to-back handshakes:
  - sym_count reads 255, then 0 after the 256th frame.
  - busy never high while senack=1.
- cclear pulse aligned so cc_s=1 on the STOP→ACK edge → sym_count=0, not 1.
- dt dropped during D0 → frame still completes; senack high for exactly 1 cycle; state returns to IDLE; next dt accepted normally.
- reset low during D1 → tx=1, senack=0, busy=0 with no clock edge. After release, a symbol 2'b01 frame is transmitted correctly.
- FE_SENDER_PARITY_EN defined, symbol 2'b11:
  - PAR bit = 0 for cycles 13–16; stop bit for cycles 17–20.
  - senack rises at cycle 21.
